// File: rtl/fft_frame_sequencer.sv
// Frame sequencer for a 64-point in-place FFT: buffers one frame from a stalling
// upstream, replays it contiguously into the FFT, then forwards the output pairs.
module fft_frame_sequencer #(
  parameter int N       = 64,
  parameter int DW      = 16,
  parameter int TIMEOUT = 512
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_re,
  input  logic [DW-1:0] s_im,
  output logic          fft_nrst,
  output logic          fft_start,
  output logic          fft_valid,
  output logic [DW-1:0] fft_re,
  output logic [DW-1:0] fft_im,
  input  logic          fft_out_start,
  input  logic [DW-1:0] fft_re0,
  input  logic [DW-1:0] fft_im0,
  input  logic [DW-1:0] fft_re1,
  input  logic [DW-1:0] fft_im1,
  output logic          m_valid,
  output logic [4:0]    m_idx,
  output logic          m_last,
  output logic [DW-1:0] m_re0,
  output logic [DW-1:0] m_im0,
  output logic [DW-1:0] m_re1,
  output logic [DW-1:0] m_im1,
  output logic          busy,
  output logic          err_timeout,
  output logic [15:0]   frame_cnt
);

  // state   | meaning
  // S_IDLE  | FFT held in reset, waiting for a full buffer
  // S_RST   | two-cycle FFT reset; first buffer read issued
  // S_STREAM| N contiguous samples into the FFT
  // S_WAIT  | waiting for output_start, bounded by TIMEOUT
  // S_DRAIN | capturing output pairs 1..31 (pair 0 is taken in S_WAIT)
  typedef enum logic [2:0] {S_IDLE, S_RST, S_STREAM, S_WAIT, S_DRAIN} state_t;

  localparam int AW = $clog2(N);
  localparam int CW = $clog2(TIMEOUT);

  state_t          state, state_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic [AW-1:0]   fill_cnt, rd_addr;
  logic            buf_full;
  logic [DW-1:0]   mem_re [N];
  logic [DW-1:0]   mem_im [N];
  logic [DW-1:0]   rd_re, rd_im;
  logic            cap, timeout_hit, stream_last, take;
  logic [4:0]      cap_idx;

  assign take    = s_valid & s_ready;
  assign s_ready = ~buf_full & (state != S_STREAM);
  assign busy    = (state != S_IDLE);
  assign fft_re  = rd_re;
  assign fft_im  = rd_im;

  always_comb begin
    state_next  = state;
    cnt_next    = cnt + CW'(1);
    cap         = 1'b0;
    cap_idx     = cnt[4:0];
    timeout_hit = 1'b0;
    stream_last = 1'b0;
    rd_addr     = cnt[AW-1:0] + AW'(1);
    fft_nrst    = 1'b1;
    fft_start   = 1'b1;
    fft_valid   = 1'b0;
    case (state)
      S_IDLE: begin
        fft_nrst  = 1'b0;
        fft_start = 1'b0;
        cnt_next  = '0;
        if (buf_full) state_next = S_RST;
      end
      S_RST: begin
        fft_nrst  = 1'b0;
        fft_start = 1'b0;
        rd_addr   = '0;
        if (cnt == CW'(1)) begin
          state_next = S_STREAM;
          cnt_next   = '0;
        end
      end
      S_STREAM: begin
        fft_valid = 1'b1;
        if (cnt == CW'(N-1)) begin
          stream_last = 1'b1;
          state_next  = S_WAIT;
          cnt_next    = '0;
        end
      end
      S_WAIT: begin
        if (fft_out_start) begin
          cap        = 1'b1;
          cap_idx    = 5'd0;
          state_next = S_DRAIN;
          cnt_next   = CW'(1);
        end else if (cnt == CW'(TIMEOUT-1)) begin
          timeout_hit = 1'b1;
          state_next  = S_IDLE;
          cnt_next    = '0;
        end
      end
      S_DRAIN: begin
        cap = 1'b1;
        if (cnt == CW'(31)) begin
          state_next = buf_full ? S_RST : S_IDLE;
          cnt_next   = '0;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      fill_cnt    <= '0;
      buf_full    <= 1'b0;
      rd_re       <= '0;
      rd_im       <= '0;
      m_valid     <= 1'b0;
      m_idx       <= '0;
      m_last      <= 1'b0;
      m_re0       <= '0;
      m_im0       <= '0;
      m_re1       <= '0;
      m_im1       <= '0;
      err_timeout <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      rd_re <= mem_re[rd_addr];
      rd_im <= mem_im[rd_addr];
      // fill and stream-end clear never coincide: s_ready is low in S_STREAM
      if (take) begin
        if (fill_cnt == AW'(N-1)) begin
          fill_cnt <= '0;
          buf_full <= 1'b1;
        end else begin
          fill_cnt <= fill_cnt + AW'(1);
        end
      end else if (stream_last) begin
        buf_full <= 1'b0;
      end
      m_valid <= cap;
      m_last  <= cap && (cap_idx == 5'd31);
      if (cap) begin
        m_idx <= cap_idx;
        m_re0 <= fft_re0;
        m_im0 <= fft_im0;
        m_re1 <= fft_re1;
        m_im1 <= fft_im1;
      end
      if (timeout_hit) err_timeout <= 1'b1;
      if (m_last) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (take) begin
      mem_re[fill_cnt] <= s_re;
      mem_im[fill_cnt] <= s_im;
    end
  end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Self-checking bench for fft_frame_sequencer: queue-based reference of the
// sample path plus a simple FFT timing model driving output pairs.
module tb_fft_frame_sequencer;
  localparam int N   = 64;
  localparam int DW  = 16;
  localparam int TMO = 512;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, s_valid, s_ready;
  logic [DW-1:0] s_re, s_im;
  logic          fft_nrst, fft_start, fft_valid;
  logic [DW-1:0] fft_re, fft_im;
  logic          fft_out_start;
  logic [DW-1:0] fft_re0, fft_im0, fft_re1, fft_im1;
  logic          m_valid, m_last, busy, err_timeout;
  logic [4:0]    m_idx;
  logic [DW-1:0] m_re0, m_im0, m_re1, m_im1;
  logic [15:0]   frame_cnt;

  fft_frame_sequencer #(.N(N), .DW(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
    .s_re(s_re), .s_im(s_im), .fft_nrst(fft_nrst), .fft_start(fft_start),
    .fft_valid(fft_valid), .fft_re(fft_re), .fft_im(fft_im),
    .fft_out_start(fft_out_start), .fft_re0(fft_re0), .fft_im0(fft_im0),
    .fft_re1(fft_re1), .fft_im1(fft_im1), .m_valid(m_valid), .m_idx(m_idx),
    .m_last(m_last), .m_re0(m_re0), .m_im0(m_im0), .m_re1(m_re1), .m_im1(m_im1),
    .busy(busy), .err_timeout(err_timeout), .frame_cnt(frame_cnt)
  );

  int n_vec = 0;
  int n_err = 0;
  int exp_fc = 0;
  logic [31:0] feed_q[$];
  logic [31:0] acc_q[$];
  int stall_mode = 0;
  bit tog = 1'b0;
  logic [3:0] h1 = '0, h2 = '0;
  logic [DW-1:0] pre0 [32], pim0 [32], pre1 [32], pim1 [32];

  // upstream source: offers the head of feed_q with the selected stall pattern
  initial begin
    s_valid = 1'b0; s_re = '0; s_im = '0;
    forever begin
      @(negedge clk);
      tog = ~tog;
      if (feed_q.size() != 0 &&
          (stall_mode == 0 || (stall_mode == 1 && tog) || (stall_mode == 2 && ($urandom % 4) != 0))) begin
        s_valid = 1'b1;
        {s_re, s_im} = feed_q[0];
      end else begin
        s_valid = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    if (!rst && s_valid && s_ready) begin
      acc_q.push_back({s_re, s_im});
      feed_q.delete(0);
    end
    h2 <= h1;
    h1 <= {busy, fft_nrst, fft_start, fft_valid};
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_frame(input int delay, input bit b2b, input bit tmo, input int abort_at);
    bit seen;
    logic [31:0] s;
    int j;
    seen = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (fft_valid) begin seen = 1'b1; break; end
      check("s_ready_fill", s_ready, acc_q.size() < N);
    end
    check("stream_start_seen", seen, 1);
    if (!seen) return;
    check("rst_phase_m1", h1, 4'b1000);
    check("rst_phase_m2", h2, 4'b1000);
    for (int k = 0; k < N; k++) begin
      if (k > 0) @(negedge clk);
      s = (acc_q.size() != 0) ? acc_q.pop_front() : 32'hxxxx_xxxx;
      check("stream_valid", fft_valid, 1);
      check("stream_nrst", fft_nrst, 1);
      check("stream_start", fft_start, 1);
      check("stream_s_ready", s_ready, 0);
      check("stream_data", {fft_re, fft_im}, s);
      if (k == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        acc_q.delete();
        exp_fc = 0;
        check("abort_valid", fft_valid, 0);
        check("abort_nrst", fft_nrst, 0);
        check("abort_busy", busy, 0);
        check("abort_s_ready", s_ready, 1);
        check("abort_err", err_timeout, 0);
        check("abort_frame_cnt", frame_cnt, 0);
        return;
      end
    end
    @(negedge clk);
    check("wait_valid", fft_valid, 0);
    check("wait_start", fft_start, 1);
    check("wait_busy", busy, 1);
    check("wait_s_ready", s_ready, acc_q.size() < N);
    if (tmo) begin
      for (j = 1; j <= 600; j++) begin
        @(negedge clk);
        check("tmo_m_valid", m_valid, 0);
        if (err_timeout) break;
      end
      check("tmo_latency", j, TMO);
      check("tmo_busy", busy, 0);
      check("tmo_nrst", fft_nrst, 0);
      check("tmo_frame_cnt", frame_cnt, exp_fc);
      return;
    end
    for (j = 0; j < delay; j++) begin
      check("wait_m_valid", m_valid, 0);
      check("wait_s_ready", s_ready, acc_q.size() < N);
      @(negedge clk);
    end
    check("wait_no_err", err_timeout, 0);
    for (int i = 0; i < 32; i++) begin
      pre0[i] = DW'($urandom); pim0[i] = DW'($urandom);
      pre1[i] = DW'($urandom); pim1[i] = DW'($urandom);
    end
    for (int i = 0; i <= 32; i++) begin
      if (i == 0) check("pre_drain_m_valid", m_valid, 0);
      else begin
        @(negedge clk);
        check("m_valid", m_valid, 1);
        check("m_idx", m_idx, i - 1);
        check("m_last", m_last, i == 32);
        check("m_pair0", {m_re0, m_im0}, {pre0[i-1], pim0[i-1]});
        check("m_pair1", {m_re1, m_im1}, {pre1[i-1], pim1[i-1]});
      end
      if (i < 32) begin
        fft_out_start = (i == 0) ? 1'b1 : 1'($urandom);
        fft_re0 = pre0[i]; fft_im0 = pim0[i]; fft_re1 = pre1[i]; fft_im1 = pim1[i];
      end else begin
        fft_out_start = 1'b0;
      end
    end
    @(negedge clk);
    exp_fc = (exp_fc + 1) % 65536;
    check("frame_cnt", frame_cnt, exp_fc);
    check("post_m_valid", m_valid, 0);
    if (b2b) begin
      check("b2b_busy", busy, 1);
      check("b2b_nrst", fft_nrst, 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    fft_out_start = 1'b0;
    fft_re0 = '0; fft_im0 = '0; fft_re1 = '0; fft_im1 = '0;
    repeat (3) @(negedge clk);
    check("rst_s_ready", s_ready, 1);
    check("rst_nrst", fft_nrst, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_err", err_timeout, 0);
    check("rst_fft_valid", fft_valid, 0);
    check("rst_fft_start", fft_start, 0);
    rst = 1'b0;

    // impulse frame, no stalls
    stall_mode = 0;
    for (int k = 0; k < N; k++) feed_q.push_back(k == 0 ? 32'h0100_0000 : 32'h0);
    run_frame(160, 0, 0, -1);

    // ramp with s_valid toggling every cycle
    stall_mode = 1;
    for (int k = 0; k < N; k++) feed_q.push_back({16'(k), 16'($urandom)});
    run_frame($urandom_range(1, 400), 0, 0, -1);

    // two frames back to back; second fills during WAIT/DRAIN
    stall_mode = 0;
    for (int k = 0; k < 2 * N; k++) feed_q.push_back($urandom);
    run_frame(160, 1, 0, -1);
    run_frame($urandom_range(0, 300), 0, 0, -1);

    // FFT never answers
    stall_mode = 2;
    for (int k = 0; k < N; k++) feed_q.push_back($urandom);
    run_frame(0, 0, 1, -1);
    check("err_sticky", err_timeout, 1);

    // reset in mid-stream, then a fresh frame
    for (int k = 0; k < N; k++) feed_q.push_back($urandom);
    run_frame(0, 0, 0, 30);
    for (int k = 0; k < N; k++) feed_q.push_back($urandom);
    run_frame($urandom_range(0, 500), 0, 0, -1);
    check("final_err", err_timeout, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
